act_skew_feeder: RTL and testbench
==================================

ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 Param FIFO_DEPTH, 4, input vector buffer depth (power of 2, >=2).
REQ-002 Param LANES, 16, systolic array rows; fixed at 16.
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 clr  in  1  synchronous clear, priority over all except rst_n.
REQ-006 start  in  1  one-cycle tile start; samples vec_count and activated_FIFO_num.
REQ-007 vec_count  in  10  vectors in the tile.
REQ-008 activated_FIFO_num  in  5  active lanes 0..16; values >16 treated as 16.
REQ-009 data_in  in  8x16  im2col column vector, byte i to lane i.
REQ-010 data_rdy_in  in  1  upstream vector valid.
REQ-011 data_consumed  out  1  accept pulse to upstream.
REQ-012 array_ready  in  1  array advance enable; low stalls skew pipeline.
REQ-013 act_out  out  8x16  skewed activation bytes.
REQ-014 act_vld_out  out  16  per-lane valid.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 tile_done  out  1  one-cycle pulse at end of tile.

Function
REQ-017 States IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN when all vec_count vectors popped from buffer; DRAIN->IDLE after (active lanes - 1) advancing cycles (0 if active<=1), tile_done pulsed in the cycle IDLE is entered.
REQ-018 start with vec_count=0: RUN->DRAIN immediately, tile_done within drain length +2 cycles, no data_consumed.
REQ-019 start while not IDLE is ignored.
REQ-020 data_consumed = (state==RUN) & data_rdy_in & buffer not full & accepted<vec_count; combinational from registered state and data_rdy_in; data_in written same edge.
REQ-021 Buffer is non-fall-through: a vector written at edge E is poppable no earlier than edge E+1.
REQ-022 Advance occurs on each edge with array_ready=1; pop happens on advance if buffer non-empty, else a bubble (data 0, valid 0) enters.
REQ-023 Lane i has i+1 registers; vector popped at advance k appears on lane 0 after k and on lane i after advance k+i.
REQ-024 Latency with array_ready=1: consume in cycle 0 -> lane 0 valid in cycle 2, lane 15 valid in cycle 17.
REQ-025 array_ready=0 holds all lane registers and buffer read side; accepts continue until full.
REQ-026 Lanes i>=active: act_out 0, act_vld_out 0 regardless of contents.
REQ-027 Full and simultaneous pop: accept permitted only if not full at start of cycle (no same-cycle credit).
REQ-028 Accepted and popped counters 10-bit, saturate at vec_count; no wrap.

Reset
REQ-029 rst_n low: state IDLE, buffer empty, lane registers 0, counters 0, all outputs 0.
REQ-030 clr: same values as reset on next edge, including mid-tile; no tile_done emitted.

Configuration
REQ-031 Macro FEEDER_PERF_CNT_EN defined: add output stall_cycles (32 bits) counting cycles busy & array_ready=0, cleared on start/clr/reset, saturating; undefined: port and counter absent, behaviour otherwise identical.

Structure
REQ-032 Package feeder_pkg holds LANES, state enum type, lane-byte typedef.
REQ-033 Sub-module vec_fifo (synchronous FIFO, width 128, depth FIFO_DEPTH, full/empty flags) holds the input buffer.

Verification
REQ-034 vec_count=3, 16 lanes, data_rdy_in high, array_ready high, vector n bytes = n*16+lane -> three data_consumed pulses; lane i shows bytes 0x0i,0x1i,0x2i in cycles 2+i..4+i; tile_done in cycle 20.
REQ-035 array_ready low after 1st consume, FIFO_DEPTH=4, vec_count=8 -> exactly 4 more accepts then data_consumed stays 0; outputs frozen; resume delivers all 8 in order.
REQ-036 activated_FIFO_num=9 -> lanes 9..15 valid 0 and data 0 throughout; drain 8 cycles.
REQ-037 clr asserted in DRAIN -> next cycle busy=0, all act_vld_out 0, no tile_done.
REQ-038 vec_count=0 start -> no data_consumed, tile_done pulsed once, busy back to 0.
REQ-039 With FEEDER_PERF_CNT_EN: 5 stalled cycles during tile -> stall_cycles=5 after tile_done.

Source files
------------

// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared lane count, state type and lane byte type for the activation skew feeder
package feeder_pkg;

  localparam int LANES = 16;
  localparam int CNT_W = 10;
  localparam int ACT_W = 5;

  typedef logic [7:0] lane_byte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Requests above the physical lane count behave as a full-width tile.
  function automatic logic [ACT_W-1:0] clamp_lanes(input logic [ACT_W-1:0] n);
    return (n > ACT_W'(LANES)) ? ACT_W'(LANES) : n;
  endfunction

endpackage

// File: rtl/vec_fifo.sv
// rtl/vec_fifo.sv - synchronous non-fall-through vector buffer with full/empty flags
module vec_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/act_skew_feeder.sv
// rtl/act_skew_feeder.sv - buffers im2col vectors and feeds them diagonally skewed into a 16-row systolic array
// Optional stall_cycles performance counter enabled by FEEDER_PERF_CNT_EN.
module act_skew_feeder #(
  parameter int FIFO_DEPTH = 4,
  parameter int LANES      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 start,
  input  logic [9:0]           vec_count,
  input  logic [4:0]           activated_FIFO_num,
  input  logic [8*LANES-1:0]   data_in,
  input  logic                 data_rdy_in,
  output logic                 data_consumed,
  input  logic                 array_ready,
  output logic [8*LANES-1:0]   act_out,
  output logic [LANES-1:0]     act_vld_out,
  output logic                 busy,
  output logic                 tile_done
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  import feeder_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
  logic [ACT_W-1:0] act_q, act_d;
  logic [ACT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             tile_done_q, tile_done_d;

  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic [8*LANES-1:0] fifo_rd_data;
  logic [ACT_W-1:0]   drain_len;

  assign data_consumed = (state_q == ST_RUN) && data_rdy_in && !fifo_full && (acc_q < vec_q);
  assign pop           = array_ready && !fifo_empty;
  assign drain_len     = (act_q == '0) ? '0 : act_q - ACT_W'(1);
  assign busy          = (state_q != ST_IDLE);
  assign tile_done     = tile_done_q;

  vec_fifo #(
    .WIDTH (8*LANES),
    .DEPTH (FIFO_DEPTH)
  ) u_vec_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .wr_en   (data_consumed),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    acc_d       = acc_q;
    pop_cnt_d   = pop_cnt_q;
    act_d       = act_q;
    drain_cnt_d = drain_cnt_q;
    tile_done_d = 1'b0;
    if (data_consumed) acc_d = acc_q + CNT_W'(1);
    if (pop && (pop_cnt_q < vec_q)) pop_cnt_d = pop_cnt_q + CNT_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          vec_d       = vec_count;
          act_d       = clamp_lanes(activated_FIFO_num);
          acc_d       = '0;
          pop_cnt_d   = '0;
          drain_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (pop_cnt_q == vec_q) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // Drain lasts until the last popped vector has reached the deepest active lane.
        if ((drain_len == '0) || (array_ready && ((drain_cnt_q + ACT_W'(1)) == drain_len))) begin
          state_d     = ST_IDLE;
          tile_done_d = 1'b1;
        end else if (array_ready) begin
          drain_cnt_d = drain_cnt_q + ACT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      state_d     = ST_IDLE;
      vec_d       = '0;
      acc_d       = '0;
      pop_cnt_d   = '0;
      act_d       = '0;
      drain_cnt_d = '0;
      tile_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      acc_q       <= '0;
      pop_cnt_q   <= '0;
      act_q       <= '0;
      drain_cnt_q <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      acc_q       <= acc_d;
      pop_cnt_q   <= pop_cnt_d;
      act_q       <= act_d;
      drain_cnt_q <= drain_cnt_d;
      tile_done_q <= tile_done_d;
    end
  end

  // Lane i is a chain of i+1 byte registers; stage 0 takes the popped byte or a bubble.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_byte_t [i:0] byte_q, byte_d;
    logic [i:0]       vld_q, vld_d;
    logic             lane_on;

    always_comb begin
      byte_d = byte_q;
      vld_d  = vld_q;
      if (array_ready) begin
        for (int j = i; j > 0; j--) begin
          byte_d[j] = byte_q[j-1];
          vld_d[j]  = vld_q[j-1];
        end
        byte_d[0] = pop ? fifo_rd_data[i*8 +: 8] : 8'h00;
        vld_d[0]  = pop;
      end
      if (clr) begin
        byte_d = '0;
        vld_d  = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        byte_q <= '0;
        vld_q  <= '0;
      end else begin
        byte_q <= byte_d;
        vld_q  <= vld_d;
      end
    end

    assign lane_on            = (act_q > ACT_W'(i));
    assign act_out[i*8 +: 8]  = lane_on ? byte_q[i] : 8'h00;
    assign act_vld_out[i]     = lane_on && vld_q[i];
  end

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && start) begin
      stall_d = '0;
    end else if ((state_q != ST_IDLE) && !array_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    if (clr) stall_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// tb/tb_act_skew_feeder.sv - self-checking bench for act_skew_feeder with a queue-based reference model
module tb_act_skew_feeder;

  localparam int DEPTH = 4;
  localparam int NL    = 16;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   vec_count = '0;
  logic [4:0]   activated_FIFO_num = '0;
  logic [127:0] data_in = '0;
  logic         data_rdy_in = 1'b0;
  logic         array_ready = 1'b0;
  logic         data_consumed;
  logic [127:0] act_out;
  logic [15:0]  act_vld_out;
  logic         busy;
  logic         tile_done;
`ifdef FEEDER_PERF_CNT_EN
  logic [31:0]  stall_cycles;
`endif

  always #5 clk = ~clk;

  act_skew_feeder #(
    .FIFO_DEPTH (DEPTH),
    .LANES      (NL)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .clr                (clr),
    .start              (start),
    .vec_count          (vec_count),
    .activated_FIFO_num (activated_FIFO_num),
    .data_in            (data_in),
    .data_rdy_in        (data_rdy_in),
    .data_consumed      (data_consumed),
    .array_ready        (array_ready),
    .act_out            (act_out),
    .act_vld_out        (act_vld_out),
    .busy               (busy),
    .tile_done          (tile_done)
`ifdef FEEDER_PERF_CNT_EN
    ,
    .stall_cycles       (stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic         o_cons, o_done, o_busy;
  logic [127:0] o_act;
  logic [15:0]  o_vld;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference model: a queue for the buffer and the history of what each advance injected.
  int           m_mode, m_vec, m_act, m_acc, m_pop, m_left;
  bit           m_done;
  logic [127:0] fq[$];
  logic [128:0] hist[$];

  task automatic model_reset();
    m_mode = M_IDLE; m_vec = 0; m_act = 0; m_acc = 0; m_pop = 0; m_left = 0; m_done = 0;
    fq.delete();
    hist.delete();
    repeat (NL) hist.push_back('0);
  endtask

  function automatic bit exp_consumed();
    return (m_mode == M_RUN) && data_rdy_in && (fq.size() < DEPTH) && (m_acc < m_vec);
  endfunction

  function automatic logic [127:0] exp_act();
    logic [127:0] r = '0;
    for (int i = 0; i < NL; i++) begin
      logic [128:0] e = hist[hist.size()-1-i];
      if (i < m_act) r[i*8 +: 8] = e[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_vld();
    logic [15:0] r = '0;
    for (int i = 0; i < NL; i++) begin
      logic [128:0] e = hist[hist.size()-1-i];
      r[i] = (i < m_act) && e[128];
    end
    return r;
  endfunction

  task automatic model_edge();
    bit cons = exp_consumed();
    m_done = 0;
    if (clr) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_IDLE: if (start) begin
        m_mode = M_RUN;
        m_vec  = int'(vec_count);
        m_act  = (activated_FIFO_num > 16) ? 16 : int'(activated_FIFO_num);
        m_acc  = 0;
        m_pop  = 0;
      end
      M_RUN: if (m_pop == m_vec) begin
        m_mode = M_DRAIN;
        m_left = (m_act > 0) ? m_act - 1 : 0;
      end
      default: begin
        if (m_left == 0) begin
          m_mode = M_IDLE; m_done = 1;
        end else if (array_ready) begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_IDLE; m_done = 1;
          end
        end
      end
    endcase
    if (array_ready) begin
      if (fq.size() > 0) begin
        hist.push_back({1'b1, fq.pop_front()});
        if (m_pop < m_vec) m_pop++;
      end else begin
        hist.push_back('0);
      end
      if (hist.size() > 40) void'(hist.pop_front());
    end
    if (cons) begin
      fq.push_back(data_in);
      m_acc++;
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    #1;
    o_cons = data_consumed; o_done = tile_done; o_busy = busy; o_act = act_out; o_vld = act_vld_out;
    chk("data_consumed", o_cons, exp_consumed());
    chk("busy", o_busy, m_mode != M_IDLE);
    chk("tile_done", o_done, m_done);
    chk("act_vld_out", o_vld, exp_vld());
    chk("act_out", o_act, exp_act());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [127:0] pat(input int n);
    logic [127:0] r;
    for (int i = 0; i < NL; i++) r[i*8 +: 8] = 8'(n*16 + i);
    return r;
  endfunction

  task automatic start_tile(input int v, input int a);
    start = 1'b1; vec_count = 10'(v); activated_FIFO_num = 5'(a);
    data_rdy_in = 1'b1; array_ready = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_tile(input int v, input int a, output int done_c, output int n_cons,
                          output int n_done, output bit masked_ok);
    int ca = (a > 16) ? 16 : a;
    done_c = -1; n_cons = 0; n_done = 0; masked_ok = 1;
    start_tile(v, a);
    for (int c = 0; c < 120; c++) begin
      data_rdy_in = 1'b1; array_ready = 1'b1; data_in = pat(n_cons);
      step();
      if (o_cons) n_cons++;
      if (o_done) begin n_done++; if (done_c < 0) done_c = c; end
      if (((o_vld >> ca) != 0) || ((o_act >> (ca*8)) != 0)) masked_ok = 0;
      if (done_c >= 0 && c >= done_c + 3) break;
    end
  endtask

  typedef struct {
    int v;
    int a;
    int exp_done;
  } tile_vec_t;

  tile_vec_t tv[7];

  initial begin
    int  dc, nc, nd, cnt, lane0_n;
    bit  mok, seen;
    bit  prev_rdy;
    logic [7:0] lane0_seq[$];

    tv[0] = '{3, 16, 20};
    tv[1] = '{0, 16, 16};
    tv[2] = '{1, 1, 4};
    tv[3] = '{0, 0, 2};
    tv[4] = '{5, 9, 15};
    tv[5] = '{2, 20, 19};
    tv[6] = '{4, 2, 7};

    model_reset();
    data_rdy_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset act_out", act_out, '0);
    chk("reset act_vld_out", act_vld_out, '0);
    chk("reset busy", busy, 1'b0);
    chk("reset tile_done", tile_done, 1'b0);
    chk("reset data_consumed", data_consumed, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    data_rdy_in = 1'b0;
    step();

    for (int k = 0; k < 7; k++) begin
      run_tile(tv[k].v, tv[k].a, dc, nc, nd, mok);
      chk($sformatf("tv%0d done cycle", k), dc, tv[k].exp_done);
      chk($sformatf("tv%0d consumes", k), nc, tv[k].v);
      chk($sformatf("tv%0d done pulses", k), nd, 1);
      chk($sformatf("tv%0d masked lanes", k), mok, 1'b1);
      chk($sformatf("tv%0d idle after", k), o_busy, 1'b0);
    end

    // Three vectors over 16 lanes: check skew timing explicitly.
    nc = 0; dc = -1;
    start_tile(3, 16);
    for (int c = 0; c < 22; c++) begin
      data_rdy_in = 1'b1; array_ready = 1'b1; data_in = pat(nc);
      step();
      if (o_cons) nc++;
      if (o_done && dc < 0) dc = c;
      foreach (tv[q]) begin
        int ln = (q == 0) ? 0 : (q == 1) ? 7 : 15;
        if (q < 3 && c >= 2 + ln && c <= 4 + ln) begin
          chk($sformatf("skew lane%0d byte c%0d", ln, c), o_act[ln*8 +: 8], 8'((c - 2 - ln)*16 + ln));
          chk($sformatf("skew lane%0d vld c%0d", ln, c), o_vld[ln], 1'b1);
        end
      end
    end
    chk("skew consumes", nc, 3);
    chk("skew done cycle", dc, 20);

    // Stall with a full buffer, then resume and confirm in-order delivery.
    nc = 0; cnt = 0; seen = 0; prev_rdy = 1'b1;
    start_tile(8, 16);
    for (int c = 0; c < 200; c++) begin
      data_rdy_in = 1'b1;
      array_ready = (c < 2 || c >= 12);
      data_in = pat(nc);
      step();
      if (o_cons) begin
        nc++;
        if (c >= 1 && c <= 11) cnt++;
      end
      if (c == 7) begin
        chk("stall lane0 frozen byte", o_act[7:0], 8'h00);
        chk("stall lane0 frozen vld", o_vld[0], 1'b1);
      end
      if (prev_rdy && o_vld[0]) lane0_seq.push_back(o_act[7:0]);
      prev_rdy = array_ready;
      if (o_done) begin seen = 1; break; end
    end
    chk("stall accepts during stall", cnt, 4);
    chk("stall total consumes", nc, 8);
    chk("stall tile_done seen", seen, 1'b1);
    lane0_n = lane0_seq.size();
    chk("stall lane0 count", lane0_n, 8);
    for (int n = 0; n < lane0_n && n < 8; n++)
      chk($sformatf("stall lane0 order %0d", n), lane0_seq[n], 8'(n*16));

    // Clear in the drain phase.
    nc = 0;
    start_tile(2, 16);
    for (int c = 0; c < 8; c++) begin
      data_rdy_in = 1'b1; array_ready = 1'b1; data_in = pat(nc);
      step();
      if (o_cons) nc++;
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    chk("clr busy", o_busy, 1'b0);
    chk("clr act_vld_out", o_vld, '0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (o_done) cnt++;
    end
    chk("clr no tile_done", cnt, 0);

`ifdef FEEDER_PERF_CNT_EN
    nc = 0; seen = 0;
    start_tile(2, 4);
    for (int c = 0; c < 100; c++) begin
      data_rdy_in = 1'b1;
      array_ready = !(c >= 1 && c <= 5);
      data_in = pat(nc);
      step();
      if (o_cons) nc++;
      if (o_done) begin seen = 1; break; end
    end
    chk("perf tile_done seen", seen, 1'b1);
    chk("perf stall_cycles", stall_cycles, 32'd5);
`endif

    // Random traffic: starts (some while busy), occasional clears, random readiness.
    for (int c = 0; c < 3000; c++) begin
      start              = ($urandom_range(0, 29) == 0);
      clr                = ($urandom_range(0, 399) == 0);
      vec_count          = 10'($urandom_range(0, 12));
      activated_FIFO_num = 5'($urandom_range(0, 31));
      data_rdy_in        = ($urandom_range(0, 9) < 7);
      array_ready        = ($urandom_range(0, 9) < 7);
      data_in            = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    start = 1'b0; clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
